// File: rtl/ram_req_ctrl_if.sv
// Request, response and RAM-port bundle for ram_req_ctrl.
// The slave modport is the controller's view; the master modport is the environment's.
interface ram_req_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Owns the port of a single-port sync RAM: init sweep after reset/clr, then
// services a read/write request stream with a 2-entry in-order read response buffer.
module ram_req_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  output logic            init_done,
  ram_req_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            rsp_count;
  logic                  rsp_pop, rsp_push, rd_accept, ready_c;
  logic [2:0]            credit;

  assign bus.rsp_valid = (rsp_count != 2'd0);
  assign bus.rsp_rdata = buf_mem[rd_ptr];
  assign bus.req_ready = ready_c;
  assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;
  assign rsp_push      = inflight;
  // Occupancy once this cycle settles; a new read needs a free slot for its eventual capture.
  assign credit        = {1'b0, rsp_count} + {2'b00, inflight} - {2'b00, rsp_pop};

  always_comb begin
    state_next   = state;
    init_done    = 1'b0;
    ready_c      = 1'b0;
    bus.ram_en   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    case (state)
      S_INIT: begin
        bus.ram_en   = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_addr = init_cnt;
        bus.ram_din  = INIT_VAL;
        if (&init_cnt) state_next = S_RUN;
      end
      S_RUN: begin
        init_done = 1'b1;
        if (clr) begin
          state_next = inflight ? S_DRAIN : S_INIT;
        end else begin
          ready_c = bus.req_we ? 1'b1 : (credit < 3'd2);
          if (bus.req_valid && ready_c) begin
            bus.ram_en   = 1'b1;
            bus.ram_we   = bus.req_we;
            bus.ram_addr = bus.req_addr;
            bus.ram_din  = bus.req_wdata;
          end
        end
      end
      S_DRAIN: state_next = S_INIT;
      default: state_next = S_INIT;
    endcase
    // The RAM has no reset of its own, so keep its port quiet while held in reset.
    if (!rst_n) begin
      bus.ram_en   = 1'b0;
      bus.ram_we   = 1'b0;
      bus.ram_addr = '0;
      bus.ram_din  = '0;
    end
  end

  assign rd_accept = bus.ram_en && !bus.ram_we && (state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      inflight  <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rsp_count <= 2'd0;
    end else begin
      state     <= state_next;
      init_cnt  <= (state == S_INIT) ? init_cnt + 1'b1 : '0;
      inflight  <= rd_accept;
      if (rsp_push) wr_ptr <= ~wr_ptr;
      if (rsp_pop)  rd_ptr <= ~rd_ptr;
      rsp_count <= rsp_count + {1'b0, rsp_push} - {1'b0, rsp_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_push) buf_mem[wr_ptr] <= bus.ram_dout;
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: behavioural sync RAM, directed stimulus, and a
// scoreboard queue of expected read data checked by an independent monitor.
module tb_ram_req_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic init_done;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] exp_mem [16];
  logic [7:0] ram_mem [16];

  ram_req_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  ram_req_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .INIT_VAL(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Single-port sync RAM: dout registered, changes only on reads.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout <= ram_mem[bus.ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else                   chk("rsp_data", {24'd0, bus.rsp_rdata}, {24'd0, exp_q.pop_front()});
      pops++;
    end
  end

  function automatic logic [31:0] ram_port();
    return {18'd0, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_din};
  endfunction

  // Expects to be entered in the first cycle of a sweep, before its negedge.
  task automatic check_sweep();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("sweep_%0d", i), ram_port(), {18'd0, 1'b1, 1'b1, 4'(i), 8'h00});
      chk("sweep_not_done", {31'd0, init_done}, 32'd0);
      exp_mem[i] = 8'h00;
    end
    @(negedge clk);
    chk("init_done_after_sweep", {31'd0, init_done}, 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [3:0] addr, input logic [7:0] wd);
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
    end
    if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
    else if (we) exp_mem[addr] = wd;
    else exp_q.push_back(exp_mem[addr]);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic stream_reads(input int first, input int last, input int budget, output int accepted);
    int idx = first;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'(first);
    for (int c = 0; c < budget && idx <= last; c++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back(exp_mem[idx]);
        idx++;
      end
      @(posedge clk); #1;
      bus.req_addr = 4'(idx);
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    accepted = idx - first;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int acc;
    int p0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ram_port", ram_port(), 32'd0);
    chk("reset_flags", {29'd0, init_done, bus.req_ready, bus.rsp_valid}, 32'd0);

    // 1: sweep after reset release, then read addr 5
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_sweep();
    @(posedge clk); #1;
    do_req(1'b0, 4'd5, 8'h00);
    idle(4);

    // 2: write then read the same address back-to-back
    do_req(1'b1, 4'd3, 8'hA5);
    do_req(1'b0, 4'd3, 8'h00);
    @(negedge clk);
    chk("rd_after_wr_t2_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rd_after_wr_t3_valid", {31'd0, bus.rsp_valid}, 32'd1);
    idle(3);

    // 3: back-pressure admits only two reads
    for (int i = 0; i < 4; i++) do_req(1'b1, 4'(i), 8'h10 + 8'(i));
    bus.rsp_ready = 1'b0;
    stream_reads(0, 3, 6, acc);
    chk("bp_accepted", 32'(acc), 32'd2);
    @(negedge clk);
    chk("bp_ready_low", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    stream_reads(2, 3, 10, acc);
    chk("bp_resume_accepted", 32'(acc), 32'd2);
    idle(5);

    // 4: full throughput with consumer always ready
    for (int i = 8; i < 16; i++) do_req(1'b1, 4'(i), 8'h80 + 8'(i));
    idle(2);
    p0 = pops;
    stream_reads(8, 15, 8, acc);
    chk("tput_accepted", 32'(acc), 32'd8);
    @(negedge clk); @(negedge clk); #1;
    chk("tput_pops", 32'(pops - p0), 32'd8);
    @(negedge clk);
    chk("tput_rsp_idle", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;

    // 5: clr the cycle after a read; clr beats a pending write
    do_req(1'b0, 4'd2, 8'h00);
    clr = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd9; bus.req_wdata = 8'h77;
    @(negedge clk);
    chk("clr_blocks_req", {30'd0, bus.req_ready, bus.ram_en}, 32'd0);
    chk("clr_cycle_done", {31'd0, init_done}, 32'd1);
    @(posedge clk); #1;
    clr = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    @(negedge clk);
    chk("drain_state", {29'd0, init_done, bus.ram_en, bus.req_ready}, 32'd0);
    chk("drain_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    @(posedge clk); #1;
    check_sweep();
    @(posedge clk); #1;
    stream_reads(0, 15, 40, acc);
    chk("post_clr_reads", 32'(acc), 32'd16);
    idle(4);

    // 6: async reset at init counter 7 restarts the sweep
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_reset_addr", ram_port(), {18'd0, 1'b1, 1'b1, 4'd7, 8'h00});
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_port", ram_port(), 32'd0);
    chk("async_reset_flags", {29'd0, init_done, bus.req_ready, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_sweep();
    @(posedge clk); #1;
    do_req(1'b0, 4'd12, 8'h00);

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
